// File: rtl/quickq_pkg.sv
// Shared types for the QuickQ priority-queue engine: FSM state encoding and
// the operation selected by IDLE arbitration.
package quickq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENQ_RD,
    ENQ_CMP,
    ENQ_WR,
    DQ_RD,
    DQ_OUT,
    SH_RD,
    SH_WR
  } states_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ENQ,
    OP_DEQ
  } qq_op_t;

endpackage

// File: rtl/quickq_if.sv
// Front-end <-> QuickQ engine bundle: enqueue ready/valid, dequeue
// request/response, and occupancy status.
interface quickq_if #(
  parameter int KW  = 16,
  parameter int CAP = 32
);
  localparam int CW = $clog2(CAP + 1);

  logic          enq_valid;
  logic [KW-1:0] enq_data;
  logic          enq_ready;
  logic          deq_req;
  logic          deq_valid;
  logic [KW-1:0] deq_data;
  logic          deq_err;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          busy;

  modport master (
    output enq_valid, enq_data, deq_req,
    input  enq_ready, deq_valid, deq_data, deq_err, count, full, empty, busy
  );

  modport slave (
    input  enq_valid, enq_data, deq_req,
    output enq_ready, deq_valid, deq_data, deq_err, count, full, empty, busy
  );

endinterface

// File: rtl/quickq_bram.sv
// Single-port synchronous BRAM, read-first, one-cycle read latency.
module quickq_bram #(
  parameter  int KW    = 16,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [KW-1:0] wdata,
  output logic [KW-1:0] rdata
);

  logic [KW-1:0] mem [DEPTH];

  // NOTE: no reset on the array or rdata; the engine never reads a slot at or
  // above count, so stale contents are harmless and the block maps to BRAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/quickq_engine.sv
// QuickQ sorted min-queue: insertion-sort enqueue walk and shift-down dequeue
// over a single-port BRAM addressed as {node, slot}.
module quickq_engine
  import quickq_pkg::*;
#(
  parameter int KW        = 16,
  parameter int NODE_SIZE = 4,
  parameter int NODES     = 8
) (
  input  logic     clk,
  input  logic     rst,
  quickq_if.slave  bus
);

  localparam int CAP = NODES * NODE_SIZE;
  localparam int AW  = $clog2(CAP);
  localparam int CW  = $clog2(CAP + 1);
  localparam int SW  = $clog2(NODE_SIZE);
  localparam int NW  = (NODES > 1) ? $clog2(NODES) : 1;

  states_t       state;
  qq_op_t        op;
  logic [KW-1:0] temp;
  logic [KW-1:0] deq_last;
  logic [SW-1:0] slot, slot_inc;
  logic [NW-1:0] node, node_inc;
  logic [CW-1:0] count_q;
  logic          deq_valid_q, deq_err_q;
  logic          is_full, is_empty, last;
  logic [AW-1:0] idx;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [KW-1:0] mem_wdata, rd_data;

  assign idx      = AW'({node, slot});
  assign last     = (CW'(idx) + CW'(1)) == count_q;
  assign is_full  = count_q == CW'(CAP);
  assign is_empty = count_q == '0;

  assign bus.enq_ready = (state == IDLE) && !is_full && !bus.deq_req;
  assign bus.deq_valid = deq_valid_q;
  assign bus.deq_err   = deq_err_q;
  assign bus.deq_data  = (state == DQ_OUT) ? rd_data : deq_last;
  assign bus.count     = count_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.busy      = state != IDLE;

  // NOTE: every always_comb output gets a default up front so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    slot_inc = slot + SW'(1);
    node_inc = node;
    if (slot == SW'(NODE_SIZE - 1)) begin
      slot_inc = '0;
      node_inc = node + NW'(1);
    end
  end

  always_comb begin
    op = OP_NONE;
    if (state == IDLE) begin
      if (bus.deq_req && !is_empty)            op = OP_DEQ;
      else if (bus.enq_valid && bus.enq_ready) op = OP_ENQ;
    end
  end

  // Writes are gated by rst so a reset edge abandons any in-flight store.
  always_comb begin
    mem_addr  = idx;
    mem_wdata = temp;
    mem_we    = 1'b0;
    case (state)
      ENQ_CMP: mem_we = temp < rd_data;
      ENQ_WR:  mem_we = 1'b1;
      SH_WR: begin
        mem_addr  = idx - AW'(1);
        mem_wdata = rd_data;
        mem_we    = 1'b1;
      end
      default: ;
    endcase
    if (rst) mem_we = 1'b0;
  end

  quickq_bram #(.KW(KW), .DEPTH(CAP)) u_bram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rd_data)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count_q     <= '0;
      temp        <= '0;
      deq_last    <= '0;
      slot        <= '0;
      node        <= '0;
      deq_valid_q <= 1'b0;
      deq_err_q   <= 1'b0;
    end else begin
      deq_valid_q <= 1'b0;
      deq_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          slot <= '0;
          node <= '0;
          if (bus.deq_req && is_empty) deq_err_q <= 1'b1;
          case (op)
            OP_DEQ: state <= DQ_RD;
            OP_ENQ: begin
              temp  <= bus.enq_data;
              state <= is_empty ? ENQ_WR : ENQ_RD;
            end
            default: ;
          endcase
        end
        ENQ_RD: state <= ENQ_CMP;
        ENQ_CMP: begin
          // Strict compare: equal keys stay ahead of the newcomer (FIFO ties).
          if (temp < rd_data) temp <= rd_data;
          slot  <= slot_inc;
          node  <= node_inc;
          state <= last ? ENQ_WR : ENQ_RD;
        end
        ENQ_WR: begin
          count_q <= count_q + CW'(1);
          state   <= IDLE;
        end
        DQ_RD: begin
          deq_valid_q <= 1'b1;
          state       <= DQ_OUT;
        end
        DQ_OUT: begin
          deq_last <= rd_data;
          slot     <= slot_inc;
          node     <= node_inc;
          if (count_q == CW'(1)) begin
            count_q <= count_q - CW'(1);
            state   <= IDLE;
          end else begin
            state <= SH_RD;
          end
        end
        SH_RD: state <= SH_WR;
        SH_WR: begin
          if (last) begin
            count_q <= count_q - CW'(1);
            state   <= IDLE;
          end else begin
            slot  <= slot_inc;
            node  <= node_inc;
            state <= SH_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quickq_engine.sv
// Self-checking bench for quickq_engine (KW=8, NODE_SIZE=4, NODES=2): vector
// table plus hand sequences; dequeued keys are matched through a scoreboard.
module tb_quickq_engine;

  localparam int KW = 8;
  localparam int NS = 4;
  localparam int NN = 2;
  localparam int CAP = NS * NN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quickq_if #(.KW(KW), .CAP(CAP)) bus ();

  quickq_engine #(.KW(KW), .NODE_SIZE(NS), .NODES(NN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          deq;        // 0: enqueue key, 1: dequeue expecting key
    logic [7:0]  key;
    int          exp_count;
    bit          exp_full;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;
  vec_t        tbl [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.deq_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_unexpected: got deq_valid=1 data=%0d, expected no output (t=%0t)",
                 bus.deq_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("deq_data", bus.deq_data, mon_exp);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("idle_reached", bus.busy, 0);
  endtask

  task automatic start_enq(input logic [7:0] k);
    int t = 0;
    @(negedge clk);
    while (!bus.enq_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("enq_ready_wait", bus.enq_ready, 1);
    bus.enq_valid = 1'b1;
    bus.enq_data  = k;
    @(posedge clk);
    #1 bus.enq_valid = 1'b0;
  endtask

  task automatic do_enq(input logic [7:0] k);
    start_enq(k);
    wait_idle();
  endtask

  task automatic do_deq(input logic [7:0] k);
    int t = 0;
    @(negedge clk);
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    exp_q.push_back(k);
    bus.deq_req = 1'b1;
    @(posedge clk);
    #1 bus.deq_req = 1'b0;
    @(negedge clk);
    check("deq_valid_cycle1", bus.deq_valid, 0);
    @(negedge clk);
    check("deq_valid_cycle2", bus.deq_valid, 1);
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    logic [7:0] drain [7];

    // Test 1: basic ordering; Test 3 prefix: fill to capacity.
    tbl[0]  = '{0, 8'd5,  1, 0};  tbl[1]  = '{0, 8'd3,  2, 0};
    tbl[2]  = '{0, 8'd9,  3, 0};  tbl[3]  = '{0, 8'd1,  4, 0};
    tbl[4]  = '{1, 8'd1,  3, 0};  tbl[5]  = '{1, 8'd3,  2, 0};
    tbl[6]  = '{1, 8'd5,  1, 0};  tbl[7]  = '{1, 8'd9,  0, 0};
    tbl[8]  = '{0, 8'd20, 1, 0};  tbl[9]  = '{0, 8'd10, 2, 0};
    tbl[10] = '{0, 8'd30, 3, 0};  tbl[11] = '{0, 8'd15, 4, 0};
    tbl[12] = '{0, 8'd25, 5, 0};  tbl[13] = '{0, 8'd12, 6, 0};
    tbl[14] = '{0, 8'd18, 7, 0};  tbl[15] = '{0, 8'd40, 8, 1};
    // Equal keys leave in arrival order; 200 vs 7 exercises the unsigned compare.
    tbl[16] = '{0, 8'd7,   1, 0}; tbl[17] = '{0, 8'd200, 2, 0};
    tbl[18] = '{0, 8'd7,   3, 0}; tbl[19] = '{0, 8'd0,   4, 0};
    tbl[20] = '{1, 8'd0,   3, 0}; tbl[21] = '{1, 8'd7,   2, 0};
    tbl[22] = '{1, 8'd7,   1, 0}; tbl[23] = '{1, 8'd200, 0, 0};
    drain = '{8'd12, 8'd15, 8'd18, 8'd20, 8'd25, 8'd30, 8'd40};

    rst = 1'b1;
    bus.enq_valid = 1'b0;
    bus.enq_data  = '0;
    bus.deq_req   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_deq_valid", bus.deq_valid, 0);
    check("rst_deq_err", bus.deq_err, 0);
    check("rst_deq_data", bus.deq_data, 0);
    check("rst_enq_ready", bus.enq_ready, 1);

    // Table part A: ordering (rows 0-7), then the tie/unsigned rows (16-23).
    for (int i = 0; i < 24; i++) begin
      if (i >= 8 && i < 16) continue;
      if (tbl[i].deq) do_deq(tbl[i].key);
      else            do_enq(tbl[i].key);
      check("tbl_count", bus.count, tbl[i].exp_count);
      check("tbl_empty", bus.empty, tbl[i].exp_count == 0);
      check("tbl_full", bus.full, tbl[i].exp_full);
    end

    // Table part B: fill to capacity.
    for (int i = 8; i < 16; i++) begin
      do_enq(tbl[i].key);
      check("fill_count", bus.count, tbl[i].exp_count);
      check("fill_full", bus.full, tbl[i].exp_full);
    end

    // Held 9th key while full, then dequeue lets it in.
    @(negedge clk);
    bus.enq_valid = 1'b1;
    bus.enq_data  = 8'd0;
    repeat (3) begin
      @(negedge clk);
      check("full_enq_ready", bus.enq_ready, 0);
      check("full_count", bus.count, CAP);
    end
    exp_q.push_back(8'd10);
    bus.deq_req = 1'b1;
    #1 check("deq_pri_enq_ready", bus.enq_ready, 0);
    @(posedge clk);
    #1 bus.deq_req = 1'b0;
    t = 0;
    @(negedge clk);
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("held_enq_ready", bus.enq_ready, 1);
    check("held_count_before", bus.count, CAP - 1);
    @(posedge clk);
    #1 bus.enq_valid = 1'b0;
    wait_idle();
    check("held_count_after", bus.count, CAP);
    do_deq(8'd0);
    for (int i = 0; i < 7; i++) do_deq(drain[i]);
    check("drain_empty", bus.empty, 1);

    // Dequeue while empty.
    @(negedge clk);
    bus.deq_req = 1'b1;
    @(posedge clk);
    #1 bus.deq_req = 1'b0;
    @(negedge clk);
    check("err_pulse", bus.deq_err, 1);
    check("err_no_valid", bus.deq_valid, 0);
    check("err_busy", bus.busy, 0);
    @(negedge clk);
    check("err_one_cycle", bus.deq_err, 0);
    check("err_count", bus.count, 0);

    // Descending keys across the node boundary; 5th enqueue walks 4 entries.
    do_enq(8'd8); do_enq(8'd7); do_enq(8'd6); do_enq(8'd5);
    start_enq(8'd4);
    n = 0;
    t = 0;
    @(negedge clk);
    while (bus.busy && t < 50) begin
      n++;
      t++;
      @(negedge clk);
    end
    check("enq5_busy_cycles", n, 9);
    check("enq5_count", bus.count, 5);
    for (int k = 4; k <= 8; k++) do_deq(8'(k));

    // Simultaneous enq_valid and deq_req with two entries.
    do_enq(8'd3);
    do_enq(8'd7);
    @(negedge clk);
    bus.enq_valid = 1'b1;
    bus.enq_data  = 8'd5;
    bus.deq_req   = 1'b1;
    exp_q.push_back(8'd3);
    #1 check("sim_enq_ready", bus.enq_ready, 0);
    @(posedge clk);
    #1 bus.deq_req = 1'b0;
    check("sim_deq_taken", bus.busy, 1);
    t = 0;
    @(negedge clk);
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("sim_first_idle_ready", bus.enq_ready, 1);
    check("sim_count_mid", bus.count, 1);
    @(posedge clk);
    #1 bus.enq_valid = 1'b0;
    wait_idle();
    check("sim_count_after", bus.count, 2);
    do_deq(8'd5);
    do_deq(8'd7);

    // Reset during the ENQ_CMP walk with three entries.
    do_enq(8'd1); do_enq(8'd2); do_enq(8'd3);
    start_enq(8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_count", bus.count, 0);
    check("rstmid_empty", bus.empty, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rstmid_no_valid", bus.deq_valid, 0);
    end
    do_enq(8'd6);
    check("post_rst_count", bus.count, 1);
    do_deq(8'd6);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quickq_engine.md
# quickq_engine

Parametrised QuickQ priority-queue engine: a sorted min-queue of `KW`-bit keys held in `NODES` nodes of `NODE_SIZE` slots in a single-port synchronous BRAM. It performs insertion-sort enqueue (compare/swap walk) and shift-down dequeue with ready/valid handshakes. It supersedes the enqueue-only control FSM with a full datapath, dequeue, occupancy tracking and error reporting. It sits between the scheduler front end and the queue storage.

## Interface
- `KW`, 16, key width in bits
- `NODE_SIZE`, 4, slots per node; power of two, ≥2
- `NODES`, 8, node count, ≥1; capacity `CAP = NODES*NODE_SIZE`
- `clk` in 1: the single clock
- `rst` in 1: synchronous, active-high reset
- `enq_valid` in 1: enqueue request
- `enq_data` in KW: key to insert
- `enq_ready` out 1: enqueue accepted on any edge where `enq_valid && enq_ready`
- `deq_req` in 1: dequeue request, sampled in IDLE only
- `deq_valid` out 1: one-cycle pulse, `deq_data` valid
- `deq_data` out KW: smallest key; holds last value otherwise
- `deq_err` out 1: one-cycle pulse, dequeue requested while empty
- `count` out $clog2(CAP+1): current occupancy
- `full`, `empty` out 1: `count==CAP`, `count==0`
- `busy` out 1: state != IDLE

## Operation
- Ordering: ascending by key, index 0 = minimum. Ties: new key is placed after existing equal keys (strict `<` swap), so equal keys leave in FIFO order.
- Address = {node, slot}. The slot counter wraps at `NODE_SIZE-1`; the node counter increments on that wrap (ADDR_INC behaviour, folded into counter logic).
- IDLE arbitration per cycle: `deq_req && !empty` → dequeue; else `deq_req && empty` → pulse `deq_err`, remain in IDLE; else `enq_valid && enq_ready` → enqueue.
- `enq_ready = (state==IDLE) && !full && !deq_req`. Dequeue has priority on simultaneous requests.
- Enqueue (n = count at accept):
  - temp ← `enq_data`, i ← 0
  - For each i < n: ENQ_RD issues a read of i. In ENQ_CMP, if temp < rd_data, write temp to i and set temp ← rd_data; then i++.
  - ENQ_WR writes temp to index n; count++ ; go to IDLE.
- Dequeue (n = count):
  - DQ_RD reads 0. DQ_OUT drives `deq_data` ← rd_data and pulses `deq_valid`.
  - For i = 1..n-1: SH_RD reads i, SH_WR writes rd_data to i-1.
  - count-- on the final state; go to IDLE.
- States: IDLE, ENQ_RD, ENQ_CMP, ENQ_WR, DQ_RD, DQ_OUT, SH_RD, SH_WR.
- Key compare is unsigned, `KW` bits. Index arithmetic uses address width $clog2(CAP) and never exceeds `CAP-1`.

## Timing
- Reset: state IDLE; count 0; `deq_valid`, `deq_err`, `busy`, `full` = 0; `deq_data` 0; `empty` 1; `enq_ready` 1 (unless `deq_req`). Memory is not cleared.
- BRAM read latency is 1 cycle; one access (read or write) per cycle.
- Enqueue: busy for 2n+1 cycles after the accept edge; `count` updates at the ENQ_WR edge.
- Dequeue: `deq_valid` is asserted in the 2nd cycle after the accept edge. Busy for 2n cycles; `count` updates at the last edge.
- `rst` mid-operation: the next cycle is IDLE with count 0. Any in-flight write is abandoned and no `deq_valid` is issued.
- Full: enqueue is held off, with no loss of `enq_data` (requester holds). Empty dequeue: only `deq_err`.

## Structure
- `quickq_pkg`: `states_t` enum and a `qq_op_t` {OP_NONE, OP_ENQ, OP_DEQ}.
- Sub-module `quickq_bram`: single-port, synchronous read/write, depth `CAP`, width `KW`.
- The engine holds the FSM, temp register, slot/node counters and occupancy counter.

## Test plan
Parameters: KW=8, NODE_SIZE=4, NODES=2 (CAP=8).
- Enqueue 5,3,9,1, then dequeue ×4 → `deq_data` 1,3,5,9; `empty`=1 afterwards.
- Enqueue 8 keys → `full`=1 and `enq_ready`=0; a 9th key (0) is held. One dequeue returns the minimum, then the held 0 is accepted; the next dequeue returns 0.
- `deq_req` while empty → `deq_err` high for exactly 1 cycle; `deq_valid`=0; count stays 0.
- Enqueue 8,7,6,5,4 (crossing the node boundary) → dequeues return 4,5,6,7,8. The 5th enqueue is busy for exactly 9 cycles.
- With count=2, assert `enq_valid` and `deq_req` together → dequeue is taken and `enq_ready`=0; the enqueue is accepted on the first IDLE cycle after `deq_req` drops.
- Assert `rst` during the ENQ_CMP walk with count=3 → next cycle IDLE, count 0, `empty`=1, no `deq_valid`.
